// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
//
// Converts one unsigned binary word to DIGITS packed BCD digits, one bit per clock.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready   input handshake; bin is sampled on the accept edge
//   bin [BIN_W-1:0]      unsigned binary value
//   out_valid, out_ready output handshake; bcd/ovf held while out_valid is high
//   bcd [4*DIGITS-1:0]   packed BCD, digit 0 in [3:0], value mod 10^DIGITS
//   ovf                  input value was >= 10^DIGITS

module bin_to_bcd_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CW    = $clog2(BIN_W + 1);
    // Wide enough to hold both the input and 10^DIGITS-1 without truncation.
    localparam int CMP_W = (BIN_W > ACC_W + 1) ? BIN_W : ACC_W + 1;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam logic [CMP_W-1:0] MAX_DEC    = CMP_W'(pow10(DIGITS) - 1);
    localparam logic [CW-1:0]    COUNT_INIT = CW'(BIN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [ACC_W-1:0]   acc;
    logic [CW-1:0]      count;
    logic               ovf_next;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shifted;
    logic [CMP_W-1:0]   bin_ext;

    assign bin_ext = CMP_W'(bin);

    // Add-3 correction on every digit from the pre-edge accumulator, in parallel.
    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            else
                acc_adj[4*i +: 4] = acc[4*i +: 4];
        end
    end

    // Shift {acc, shreg} left; whatever leaves the top digit is dropped,
    // which yields the mod 10^DIGITS wrap.
    assign acc_shifted = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            shreg     <= '0;
            acc       <= '0;
            count     <= '0;
            ovf_next  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= bin;
                        acc      <= '0;
                        count    <= COUNT_INIT;
                        ovf_next <= (bin_ext > MAX_DEC);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= acc_shifted;
                    shreg <= shreg << 1;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        bcd       <= acc_shifted;
                        ovf       <= ovf_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq

module tb_bin_to_bcd_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] bcd;
    logic       ovf;

    int errors;
    int checks;

    bin_to_bcd_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers v, waits for out_valid, returns result and cycles after the accept edge.
    task automatic convert(input logic [6:0] v, output logic [7:0] b, output logic o,
                           output int lat, output bit timeout);
        int w;
        timeout = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        bin      = v;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
        b = bcd;
        o = ovf;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b bcd=%h ovf=%b, required 1 0 00 0",
                     in_ready, out_valid, bcd, ovf);
        end
        #12;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] b;
        logic o;
        int lat;
        bit to;
        convert(7'd57, b, o, lat, to);
        checks++;
        if (to || lat !== 7) begin
            errors++;
            $display("FAIL basic_latency: got %0d (timeout=%0d), required 7", lat, to);
        end
        checks++;
        if (b !== 8'h57 || o !== 1'b0) begin
            errors++;
            $display("FAIL basic_value: bcd=%h ovf=%b, required 57 0", b, o);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake: out_valid=%b in_ready=%b, required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] b;
        logic [7:0] exp;
        logic o;
        int lat;
        bit to;
        for (int v = 0; v < 100; v++) begin
            exp = 8'(((v / 10) << 4) | (v % 10));
            convert(7'(v), b, o, lat, to);
            checks++;
            if (to || b !== exp || o !== 1'b0 || lat !== 7) begin
                errors++;
                $display("FAIL exhaustive_%0d: bcd=%h ovf=%b lat=%0d, required %h 0 7",
                         v, b, o, lat, exp);
            end
            handshake();
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic o;
        int lat;
        bit to;
        logic [6:0] vin  [3] = '{7'd100, 7'd127, 7'd110};
        logic [7:0] vexp [3] = '{8'h00, 8'h27, 8'h10};
        for (int i = 0; i < 3; i++) begin
            convert(vin[i], b, o, lat, to);
            checks++;
            if (to || b !== vexp[i] || o !== 1'b1) begin
                errors++;
                $display("FAIL overflow_%0d: bcd=%h ovf=%b, required %h 1", vin[i], b, o, vexp[i]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        logic o;
        int lat;
        bit to;
        convert(7'd57, b, o, lat, to);
        in_valid = 1'b1;
        bin      = 7'd12;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd !== 8'h57 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: out_valid=%b in_ready=%b bcd=%h ovf=%b, required 1 0 57 0",
                         i, out_valid, in_ready, bcd, ovf);
            end
        end
        @(posedge clk);
        #1;
        handshake();
        // in_valid still high across the handshake edge; it must not be accepted there.
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd !== 8'h57) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b bcd=%h, required 0 1 57",
                     out_valid, in_ready, bcd);
        end
        in_valid = 1'b0;
        convert(7'd12, b, o, lat, to);
        checks++;
        if (to || b !== 8'h12 || o !== 1'b0 || lat !== 7) begin
            errors++;
            $display("FAIL backpressure_next: bcd=%h ovf=%b lat=%0d, required 12 0 7", b, o, lat);
        end
        handshake();
    endtask

    task automatic test_abort();
        logic [7:0] b;
        logic o;
        int lat;
        bit to;
        @(negedge clk);
        in_valid = 1'b1;
        bin      = 7'd88;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_accept: in_ready=%b, required 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: in_ready=%b out_valid=%b bcd=%h ovf=%b, required 1 0 00 0",
                     in_ready, out_valid, bcd, ovf);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result: out_valid=%b, required 0", out_valid);
        end
        convert(7'd42, b, o, lat, to);
        checks++;
        if (to || b !== 8'h42 || o !== 1'b0 || lat !== 7) begin
            errors++;
            $display("FAIL abort_next: bcd=%h ovf=%b lat=%0d, required 42 0 7", b, o, lat);
        end
        handshake();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        bin       = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_exhaustive();
        test_overflow();
        test_backpressure();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Iterative shift-and-add-3 (double-dabble) converter from unsigned binary to packed BCD. It produces the packed 2-digit BCD operands consumed by the team's BCD add/subtract datapath. It accepts one binary word through a valid/ready handshake and returns one packed BCD word through a valid/ready handshake. One bit is processed per clock.

Parameters:
DIGITS, 2, number of BCD digits in the output (output width 4*DIGITS).
BIN_W, 7, width of the binary input. Must satisfy BIN_W >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  binary word on bin is offered
in_ready  output  1  converter can accept a word (high only in IDLE)
bin  input  BIN_W  unsigned binary value, sampled on the accept edge
out_valid  output  1  bcd/ovf hold a completed result
out_ready  input  1  consumer takes the result
bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]; value mod 10^DIGITS
ovf  output  1  input value was >= 10^DIGITS

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- While rst is high: state=IDLE, in_ready=1, out_valid=0, bcd=0, ovf=0, and internal shift/count registers are 0.
- States:
  - IDLE: in_ready=1. An accept occurs on an edge where in_valid=1. On accept: capture bin into the shift register, clear the BCD accumulator to 0, set count=BIN_W, latch ovf_next=(bin > 10^DIGITS-1), and go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. On each edge:
    - every accumulator digit >= 5 gets +3, applied to all digits in parallel from the pre-edge values;
    - then {acc, shreg} is shifted left by 1, so the binary MSB enters acc[0];
    - count decrements.
    - On the edge where count goes 1->0: load bcd from the final accumulator value, load ovf from ovf_next, and go to DONE.
  - DONE: out_valid=1, in_ready=0. bcd and ovf are held stable. On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: if the accept is at edge k, out_valid is high starting after edge k+BIN_W. Default BIN_W=7 gives 7 cycles.
- Throughput: at most one word per BIN_W+2 cycles. There is no accept in the same cycle as the DONE->IDLE handshake.
- in_valid and bin are ignored outside IDLE.
- Overflow: the accumulator is truncated to 4*DIGITS bits, and bits leaving the top digit are discarded. bcd therefore equals value mod 10^DIGITS, with the same wrap as the BCD adder. ovf is valid exactly while out_valid=1.
- bcd and ovf keep their last values after the handshake, until the next completion overwrites them.
- Every output digit is always in 0..9. The +3 correction is applied only when a digit is >= 5.
- Asserting rst mid-SHIFT or in DONE aborts the conversion. No out_valid is produced for the aborted word.
- Width rules: count width is clog2(BIN_W+1). The 10^DIGITS-1 comparison is done at elaboration-constant width max(BIN_W, 4*DIGITS+1).

Test Plan:
- Reset: rst pulse asynchronous to clk -> in_ready=1, out_valid=0, bcd=8'h00, ovf=0 with no clock edge required.
- Basic: bin=7'd57, in_valid for 1 cycle -> out_valid high exactly 7 cycles after the accept edge, bcd=8'h57, ovf=0. With out_ready=1, out_valid drops on the next edge.
- Boundaries: exhaustive 0..99 -> bcd equals the packed decimal, ovf=0. For example, 0->8'h00, 9->8'h09, 10->8'h10, 99->8'h99.
- Overflow: 100->bcd=8'h00, ovf=1. 127->bcd=8'h27, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after completion -> bcd/ovf stable and in_ready=0. While in DONE, offer bin=7'd12 with in_valid=1 -> ignored. After the handshake, offering 12 is accepted and gives 8'h12.
- Abort: accept 7'd88, assert rst after 3 SHIFT cycles -> outputs return to reset values immediately. A next conversion of 7'd42 yields 8'h42 with the correct latency.
